// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reset_sequencer_pkg
// Brief   : Shared types and helpers for the reset sequencer.
// Revision: 1.0  initial release
// ============================================================================
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_TRAP = 2'd1,
        CAUSE_WDT  = 2'd2
    } cause_t;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int TRAP_COUNT_W = 4;

    // $clog2 of 1 is 0; a counter still needs at least one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_wdt.sv
`default_nettype none
// ============================================================================
// Module  : reset_sequencer_wdt
// Brief   : Watchdog: kick level-change detect plus idle counter, flags expiry.
// Revision: 1.0  initial release
// ============================================================================
module reset_sequencer_wdt
    import reset_sequencer_pkg::*;
#(
    parameter int WDT_CYCLES = 1024
) (
    input  logic clk,
    input  logic power_on_reset,
    input  logic kick,
    input  logic active,
    input  logic clear,
    output logic expire
);

    localparam int              CNT_W    = cnt_width(WDT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDT_CYCLES - 1);

    logic             kick_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             kicked;

    assign kicked = kick ^ kick_prev_q;
    assign expire = active && !kicked && (cnt_q == CNT_LAST);

    // Counter idles at zero outside RUN so every RUN stint starts fresh.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || !active || kicked) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        kick_prev_q <= kick;
        if (power_on_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : reset_sequencer
// Brief   : System reset generator with trap restart, lock-up and optional
//           watchdog (enabled by defining RESET_SEQUENCER_WDT_EN).
// Revision: 1.0  initial release
// ============================================================================
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES  = 8,
    parameter int TRAP_RETRIES = 3,
    parameter int WDT_CYCLES   = 1024
) (
    input  logic                    clk,
    input  logic                    power_on_reset,
    input  logic                    trap,
    input  logic                    kick,
    output logic                    system_reset,
    output logic [TRAP_COUNT_W-1:0] trap_count,
    output logic                    locked,
    output logic [1:0]              reset_cause
);

    localparam int                       HOLD_W      = cnt_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]        HOLD_LOAD   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TRAP_COUNT_W-1:0]  RETRY_LIMIT = TRAP_COUNT_W'(TRAP_RETRIES);
    localparam logic [TRAP_COUNT_W-1:0]  COUNT_MAX   = '1;

    state_t                  state_q,        state_d;
    logic [HOLD_W-1:0]       hold_cnt_q,     hold_cnt_d;
    logic [TRAP_COUNT_W-1:0] trap_count_q,   trap_count_d;
    cause_t                  cause_q,        cause_d;
    logic                    system_reset_q, system_reset_d;
    logic                    locked_q,       locked_d;
    logic                    wdt_expire;

`ifdef RESET_SEQUENCER_WDT_EN
    reset_sequencer_wdt #(
        .WDT_CYCLES     (WDT_CYCLES)
    ) u_wdt (
        .clk            (clk),
        .power_on_reset (power_on_reset),
        .kick           (kick),
        .active         (state_q == ST_RUN),
        .clear          (state_d != ST_RUN),
        .expire         (wdt_expire)
    );
`else
    logic unused_kick;
    assign unused_kick = kick;
    assign wdt_expire  = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        trap_count_d   = trap_count_q;
        cause_d        = cause_q;
        system_reset_d = system_reset_q;
        locked_d       = locked_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d        = ST_RUN;
                    system_reset_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                // A trap outranks a simultaneous watchdog expiry.
                if (trap) begin
                    system_reset_d = 1'b1;
                    if (trap_count_q < RETRY_LIMIT) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_LOAD;
                        cause_d    = CAUSE_TRAP;
                        if (trap_count_q != COUNT_MAX) begin
                            trap_count_d = trap_count_q + TRAP_COUNT_W'(1);
                        end
                    end else begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end
                end else if (wdt_expire) begin
                    state_d        = ST_HOLD;
                    hold_cnt_d     = HOLD_LOAD;
                    cause_d        = CAUSE_WDT;
                    system_reset_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                system_reset_d = 1'b1;
                locked_d       = 1'b1;
            end
            default: begin
                state_d        = ST_HOLD;
                hold_cnt_d     = HOLD_LOAD;
                system_reset_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (power_on_reset) begin
            state_q        <= ST_HOLD;
            hold_cnt_q     <= HOLD_LOAD;
            trap_count_q   <= '0;
            cause_q        <= CAUSE_POR;
            system_reset_q <= 1'b1;
            locked_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            trap_count_q   <= trap_count_d;
            cause_q        <= cause_d;
            system_reset_q <= system_reset_d;
            locked_q       <= locked_d;
        end
    end

    assign system_reset = system_reset_q;
    assign trap_count   = trap_count_q;
    assign locked       = locked_q;
    assign reset_cause  = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_reset_sequencer
// Brief   : Randomized self-checking bench for reset_sequencer; watchdog
//           scenarios are included when RESET_SEQUENCER_WDT_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int HOLD    = 8;
    localparam int RETRIES = 3;
    localparam int WDT     = 16;
`ifdef RESET_SEQUENCER_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       power_on_reset = 1'b1;
    logic       trap = 1'b0;
    logic       kick = 1'b0;
    logic       system_reset;
    logic [3:0] trap_count;
    logic       locked;
    logic [1:0] reset_cause;

    reset_sequencer #(
        .HOLD_CYCLES    (HOLD),
        .TRAP_RETRIES   (RETRIES),
        .WDT_CYCLES     (WDT)
    ) dut (
        .clk            (clk),
        .power_on_reset (power_on_reset),
        .trap           (trap),
        .kick           (kick),
        .system_reset   (system_reset),
        .trap_count     (trap_count),
        .locked         (locked),
        .reset_cause    (reset_cause)
    );

    always #2 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: remaining hold cycles, lock flag, restart count,
    // last cause, and number of consecutive unkicked RUN cycles.
    int   m_hold   = HOLD;
    bit   m_locked = 1'b0;
    int   m_traps  = 0;
    int   m_cause  = 0;
    int   m_idle   = 0;
    logic m_prev   = 1'b0;
    logic k        = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic p, input logic t, input logic kk);
        if (p) begin
            m_hold = HOLD; m_locked = 1'b0; m_traps = 0; m_cause = 0; m_idle = 0;
        end else if (m_locked) begin
            m_idle = 0;
        end else if (m_hold > 0) begin
            m_hold--; m_idle = 0;
        end else if (t) begin
            if (m_traps < RETRIES) begin
                m_traps++; m_cause = 1; m_hold = HOLD;
            end else begin
                m_locked = 1'b1;
            end
        end else if (WDT_ON && kk != m_prev) begin
            m_idle = 0;
        end else if (WDT_ON && m_idle + 1 == WDT) begin
            m_cause = 2; m_hold = HOLD; m_idle = 0;
        end else begin
            m_idle++;
        end
        m_prev = kk;
    endtask

    task automatic cyc(input logic p, input logic t, input logic kk);
        power_on_reset = p;
        trap           = t;
        kick           = kk;
        @(posedge clk);
        model_step(p, t, kk);
        @(negedge clk);
        check("system_reset", 32'(system_reset), 32'((m_hold > 0) || m_locked));
        check("locked",       32'(locked),       32'(m_locked));
        check("trap_count",   32'(trap_count),   32'(m_traps));
        check("reset_cause",  32'(reset_cause),  32'(m_cause));
    endtask

    task automatic wait_run();
        int n = 0;
        while (system_reset && n < 64) begin
            cyc(1'b0, 1'b0, k);
            n++;
        end
        check("run_reached", 32'(system_reset), 32'd0);
    endtask

    task automatic hold_len(input string tag);
        int n = 0;
        do begin
            cyc(1'b0, 1'b0, k);
            n++;
        end while (system_reset && n < 64);
        check(tag, 32'(n), 32'(HOLD));
    endtask

    initial begin
        // Power-on reset, then measure the hold length.
        repeat (5) cyc(1'b1, 1'b0, k);
        check("por_cause", 32'(reset_cause), 32'd0);
        hold_len("por_hold_len");
        check("por_count", 32'(trap_count), 32'd0);

        // Single trap restart.
        repeat ($urandom_range(1, 10)) cyc(1'b0, 1'b0, k);
        cyc(1'b0, 1'b1, k);
        check("trap_reset", 32'(system_reset), 32'd1);
        hold_len("trap_hold_len");
        check("trap_count1", 32'(trap_count), 32'd1);
        check("trap_cause", 32'(reset_cause), 32'd1);

        // Exhaust the retries and lock up.
        for (int i = 0; i < 3; i++) begin
            wait_run();
            repeat ($urandom_range(1, 10)) begin
                k ^= ($urandom_range(0, 3) == 0);
                cyc(1'b0, 1'b0, k);
            end
            cyc(1'b0, 1'b1, k);
        end
        check("locked_set", 32'(locked), 32'd1);
        check("locked_count", 32'(trap_count), 32'd3);
        for (int i = 0; i < 500; i++) begin
            k ^= ($urandom_range(0, 3) == 0);
            cyc(1'b0, 1'($urandom_range(0, 1)), k);
        end
        check("locked_hold", 32'(system_reset), 32'd1);

        // POR out of LOCKED.
        cyc(1'b1, 1'b0, k);
        check("unlock_locked", 32'(locked), 32'd0);
        check("unlock_count", 32'(trap_count), 32'd0);
        hold_len("unlock_hold_len");

`ifdef RESET_SEQUENCER_WDT_EN
        begin
            int restarts = 0;
            int n = 0;
            for (int i = 0; i < 200; i++) begin
                if (i % 10 == 9) k = ~k;
                cyc(1'b0, 1'b0, k);
                restarts += int'(system_reset);
            end
            check("wdt_kicked_quiet", 32'(restarts), 32'd0);
            do begin
                cyc(1'b0, 1'b0, k);
                n++;
            end while (!system_reset && n < 64);
            check("wdt_fired", 32'(system_reset), 32'd1);
            check("wdt_cause", 32'(reset_cause), 32'd2);
            check("wdt_count", 32'(trap_count), 32'd0);

            // A kick in the expiry cycle cancels the restart.
            wait_run();
            n = 0;
            while (m_idle + 1 != WDT && n < 64) begin cyc(1'b0, 1'b0, k); n++; end
            k = ~k;
            cyc(1'b0, 1'b0, k);
            check("wdt_kick_cancel", 32'(system_reset), 32'd0);

            // Trap and expiry together: trap wins.
            n = 0;
            while (m_idle + 1 != WDT && n < 64) begin cyc(1'b0, 1'b0, k); n++; end
            cyc(1'b0, 1'b1, k);
            check("both_cause", 32'(reset_cause), 32'd1);
            check("both_count", 32'(trap_count), 32'd1);
        end
`endif

        // POR in the middle of a trap hold.
        wait_run();
        cyc(1'b0, 1'b1, k);
        repeat (3) cyc(1'b0, 1'b0, k);
        cyc(1'b1, 1'b0, k);
        check("midhold_count", 32'(trap_count), 32'd0);
        check("midhold_cause", 32'(reset_cause), 32'd0);
        hold_len("midhold_len");

        // Random soak against the model.
        for (int i = 0; i < 3000; i++) begin
            k ^= ($urandom_range(0, 11) == 0);
            cyc(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 39) == 0), k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
